// File: rtl/vscale_src_b_stage_if.sv
// vscale_src_b_stage_if: operand-B stage bus (decode-side inputs, bypass channels, registered outputs)
interface vscale_src_b_stage_if #(
   parameter int XLEN    = 32,
   parameter int NUM_BYP = 2,
   parameter int REG_AW  = 5
);
   logic [1:0]              src_b_sel;
   logic [XLEN-1:0]         imm;
   logic [XLEN-1:0]         rs2_data;
   logic [REG_AW-1:0]       rs2_addr;
   logic                    in_valid;
   logic                    stall;
   logic                    kill;
   logic [NUM_BYP-1:0]      byp_valid;
   logic [NUM_BYP*REG_AW-1:0] byp_addr;
   logic [NUM_BYP*XLEN-1:0] byp_data;
   logic [XLEN-1:0]         alu_src_b;
   logic                    out_valid;
   logic                    byp_hit;

   modport master (
      output src_b_sel, imm, rs2_data, rs2_addr, in_valid, stall, kill,
             byp_valid, byp_addr, byp_data,
      input  alu_src_b, out_valid, byp_hit
   );

   modport slave (
      input  src_b_sel, imm, rs2_data, rs2_addr, in_valid, stall, kill,
             byp_valid, byp_addr, byp_data,
      output alu_src_b, out_valid, byp_hit
   );
endinterface

// File: rtl/vscale_src_b_stage.sv
// vscale_src_b_stage: registered ALU operand-B select with rs2 bypass and stall refresh.
// Define SRC_B_BYPASS_EN to enable bypass matching; otherwise RS2 always reads rs2_data.
module vscale_src_b_stage #(
   parameter int XLEN    = 32,
   parameter int NUM_BYP = 2,
   parameter int REG_AW  = 5
) (
   input logic clk,
   input logic reset_n,
   vscale_src_b_stage_if.slave b
);
   typedef enum logic [1:0] {SEL_RS2, SEL_IMM, SEL_FOUR, SEL_ZERO} sel_t;

   sel_t              held_sel;
   logic [REG_AW-1:0] held_addr;
   logic [XLEN-1:0]   fwd_data;
   logic [XLEN-1:0]   ref_data;
   logic [XLEN-1:0]   sel_val;
   logic              fwd_hit;
   logic              ref_hit;
   sel_t              sel;

   assign sel = sel_t'(b.src_b_sel);

`ifdef SRC_B_BYPASS_EN
   // descending scan so the lowest matching channel is the last (winning) write
   always_comb begin
      fwd_data = b.rs2_data;
      fwd_hit  = 1'b0;
      ref_data = b.alu_src_b;
      ref_hit  = 1'b0;
      for (int i = NUM_BYP - 1; i >= 0; i--) begin
         if (b.byp_valid[i] && b.rs2_addr != '0 && b.byp_addr[i*REG_AW +: REG_AW] == b.rs2_addr) begin
            fwd_data = b.byp_data[i*XLEN +: XLEN];
            fwd_hit  = 1'b1;
         end
         if (b.byp_valid[i] && held_addr != '0 && b.byp_addr[i*REG_AW +: REG_AW] == held_addr) begin
            ref_data = b.byp_data[i*XLEN +: XLEN];
            ref_hit  = 1'b1;
         end
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{b.byp_valid, b.byp_addr, b.byp_data, held_addr};
   assign fwd_data   = b.rs2_data;
   assign fwd_hit    = 1'b0;
   assign ref_data   = b.alu_src_b;
   assign ref_hit    = 1'b0;
`endif

   assign sel_val = sel == SEL_RS2  ? fwd_data :
                    sel == SEL_IMM  ? b.imm :
                    sel == SEL_FOUR ? XLEN'(4) : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         b.alu_src_b <= '0;
         b.out_valid <= 1'b0;
         b.byp_hit   <= 1'b0;
         held_sel    <= SEL_ZERO;
         held_addr   <= '0;
      end else if (b.kill) begin
         b.out_valid <= 1'b0;
         b.byp_hit   <= 1'b0;
      end else if (b.stall) begin
         if (b.out_valid && held_sel == SEL_RS2 && ref_hit) begin
            b.alu_src_b <= ref_data;
            b.byp_hit   <= 1'b1;
         end
      end else if (b.in_valid) begin
         b.alu_src_b <= sel_val;
         b.out_valid <= 1'b1;
         b.byp_hit   <= sel == SEL_RS2 && fwd_hit;
         held_sel    <= sel;
         held_addr   <= b.rs2_addr;
      end else begin
         b.out_valid <= 1'b0;
         b.byp_hit   <= 1'b0;
      end
   end
endmodule
